alu_ctrl_md: RTL and testbench

Execute-stage ALU control decoder with an integrated iterative RV32M multiply/divide sequencer, parametrised in datapath width. It decodes `alu_op`/`func3`/`func7` into the 4-bit ALU control code used by the main ALU. It also runs M-extension operations over multiple cycles, stalling the pipeline until the result is ready. It sits between the ID/EX pipeline register and the EX-stage ALU/result mux.

---
 rtl/alu_ctrl_md.sv | 237 +++++++++++++++++++++++
 tb/tb_alu_ctrl_md.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_md.sv
// -----------------------------------------------------------------------------
// alu_ctrl_md
// Execute-stage ALU control decoder plus an iterative RV32M multiply/divide
// sequencer. The decoder turns alu_op/func3/func7 into the 4-bit code used by
// the main ALU. M-extension operations run one shift-add (multiply) or one
// restoring-subtract (divide) step per cycle, and the pipeline is stalled
// until the result is ready.
//
// Configuration macro: ALU_CTRL_MD_DIV_EN
//   defined   -> DIV/DIVU/REM/REMU supported (iterative plus one-cycle
//                special cases for x/0 and most-negative / -1)
//   undefined -> funct3 1xx M-ops decode as illegal; no divider is built
//
// Ports
//   i_clk        rising-edge clock
//   i_rst        synchronous, active-high reset
//   i_in_valid   instruction present in EX
//   i_alu_op     major class (000 R, 001 load, 010 store, 011 branch,
//                100 U, 101 J, 110 I-arith, 111 JALR)
//   i_func3      instruction funct3
//   i_func7      instruction funct7
//   i_op_a       rs1 value
//   i_op_b       rs2 value
//   i_flush      kill the in-flight EX instruction
//   o_alu_ctrl   ALU control code (combinational)
//   o_md_sel     decode is a supported M-op (combinational)
//   o_illegal    unsupported R-type funct7/funct3 combination (combinational)
//   o_stall      hold IF/ID/EX
//   o_md_valid   o_md_result valid this cycle
//   o_md_result  M-op result
// -----------------------------------------------------------------------------
module alu_ctrl_md #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_in_valid,
  input  logic [2:0]      i_alu_op,
  input  logic [2:0]      i_func3,
  input  logic [6:0]      i_func7,
  input  logic [XLEN-1:0] i_op_a,
  input  logic [XLEN-1:0] i_op_b,
  input  logic            i_flush,
  output logic [3:0]      o_alu_ctrl,
  output logic            o_md_sel,
  output logic            o_illegal,
  output logic            o_stall,
  output logic            o_md_valid,
  output logic [XLEN-1:0] o_md_result
);

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1001;
  localparam logic [3:0] ALU_XOR  = 4'b1100;
  localparam logic [3:0] ALU_SLL  = 4'b1110;
  localparam logic [3:0] ALU_SRL  = 4'b1101;
  localparam logic [3:0] ALU_SRA  = 4'b1111;

  localparam int CW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  // Shared R/I-arith map; allow_sub is low for I-arith where funct3 000 is ADDI.
  function automatic logic [3:0] f_arith(input logic [2:0] f3, input logic alt,
                                         input logic allow_sub);
    case (f3)
      3'b000:  f_arith = (alt & allow_sub) ? ALU_SUB : ALU_ADD;
      3'b001:  f_arith = ALU_SLL;
      3'b010:  f_arith = ALU_SLT;
      3'b011:  f_arith = ALU_SLTU;
      3'b100:  f_arith = ALU_XOR;
      3'b101:  f_arith = alt ? ALU_SRA : ALU_SRL;
      3'b110:  f_arith = ALU_OR;
      default: f_arith = ALU_AND;
    endcase
  endfunction

  // ---------------------------------------------------------------- decode
  logic w_is_r, w_f7_base, w_f7_alt, w_f7_m, w_m_ok;

  assign w_is_r    = (i_alu_op == 3'b000);
  assign w_f7_base = (i_func7 == 7'b0000000);
  assign w_f7_alt  = (i_func7 == 7'b0100000);
  assign w_f7_m    = (i_func7 == 7'b0000001);
`ifdef ALU_CTRL_MD_DIV_EN
  assign w_m_ok    = 1'b1;
`else
  assign w_m_ok    = ~i_func3[2];
`endif

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    o_alu_ctrl = ALU_ADD;
    case (i_alu_op)
      3'b000: if (w_f7_base | w_f7_alt) o_alu_ctrl = f_arith(i_func3, i_func7[5], 1'b1);
      3'b011: begin
        case (i_func3[2:1])
          2'b00:   o_alu_ctrl = ALU_SUB;
          2'b11:   o_alu_ctrl = ALU_SLTU;
          default: o_alu_ctrl = ALU_SLT;
        endcase
      end
      3'b101:  o_alu_ctrl = ALU_AND;
      3'b110:  o_alu_ctrl = f_arith(i_func3, i_func7[5], 1'b0);
      default: o_alu_ctrl = ALU_ADD;
    endcase
  end

  assign o_md_sel  = w_is_r & w_f7_m & w_m_ok;
  assign o_illegal = w_is_r & (~(w_f7_base | w_f7_alt | w_f7_m)
                             | (w_f7_alt & ~((i_func3 == 3'b000) | (i_func3 == 3'b101)))
                             | (w_f7_m & ~w_m_ok));

  // -------------------------------------------------------- operand prep
  logic            w_accept, w_a_signed, w_b_signed, w_a_neg, w_b_neg, w_neg_res;
  logic [XLEN-1:0] w_mag_a, w_mag_b;

  assign w_accept   = i_in_valid & o_md_sel & ~i_flush;
  // Signed dividend/multiplicand: MULH, MULHSU, DIV, REM. Signed rs2: MULH, DIV, REM.
  assign w_a_signed = (i_func3 == 3'b001) | (i_func3 == 3'b010) |
                      (i_func3 == 3'b100) | (i_func3 == 3'b110);
  assign w_b_signed = (i_func3 == 3'b001) | (i_func3 == 3'b100) | (i_func3 == 3'b110);
  assign w_a_neg    = w_a_signed & i_op_a[XLEN-1];
  assign w_b_neg    = w_b_signed & i_op_b[XLEN-1];
  assign w_mag_a    = w_a_neg ? -i_op_a : i_op_a;
  assign w_mag_b    = w_b_neg ? -i_op_b : i_op_b;
  // Remainder follows the dividend; everything else follows the sign product.
  assign w_neg_res  = (i_func3[2] & i_func3[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);

  logic            w_special;
  logic [XLEN-1:0] w_special_res;
`ifdef ALU_CTRL_MD_DIV_EN
  logic w_div_zero, w_div_ovf;
  assign w_div_zero    = i_func3[2] & (i_op_b == '0);
  assign w_div_ovf     = i_func3[2] & ~i_func3[0] & (i_op_a == {1'b1, {(XLEN-1){1'b0}}})
                       & (&i_op_b);
  assign w_special     = w_div_zero | w_div_ovf;
  assign w_special_res = w_div_zero ? (i_func3[1] ? i_op_a : '1)
                                    : (i_func3[1] ? '0 : i_op_a);
`else
  assign w_special     = 1'b0;
  assign w_special_res = '0;
`endif

  // ---------------------------------------------------------------- state
  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_hi, r_lo, r_mag_b, r_result;
  logic            r_neg, r_mul_lo;
  logic [XLEN-1:0] w_hi_nxt, w_lo_nxt, w_final;

  // Multiply: {hi,lo} holds partial product with the multiplier in lo.
  logic [XLEN:0]     w_sum;
  logic [2*XLEN-1:0] w_prod, w_prod_s;
  logic [XLEN-1:0]   w_mul_res;
  assign w_sum     = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mag_b} : '0);
  assign w_prod    = {w_sum[XLEN:1], w_sum[0], r_lo[XLEN-1:1]};
  assign w_prod_s  = r_neg ? -w_prod : w_prod;
  assign w_mul_res = r_mul_lo ? w_prod_s[XLEN-1:0] : w_prod_s[2*XLEN-1:XLEN];

`ifdef ALU_CTRL_MD_DIV_EN
  // Divide: hi is the partial remainder, lo shifts the dividend out and the
  // quotient bits in.
  logic            r_div, r_rem;
  logic [XLEN+1:0] w_rem_sh, w_diff;
  logic            w_borrow;
  logic [XLEN-1:0] w_div_sel;
  assign w_rem_sh  = {1'b0, r_hi, r_lo[XLEN-1]};
  assign w_diff    = w_rem_sh - {2'b00, r_mag_b};
  assign w_borrow  = w_diff[XLEN+1];
  assign w_hi_nxt  = r_div ? (w_borrow ? w_rem_sh[XLEN-1:0] : w_diff[XLEN-1:0])
                           : w_prod[2*XLEN-1:XLEN];
  assign w_lo_nxt  = r_div ? {r_lo[XLEN-2:0], ~w_borrow} : w_prod[XLEN-1:0];
  assign w_div_sel = r_rem ? w_hi_nxt : w_lo_nxt;
  assign w_final   = r_div ? (r_neg ? -w_div_sel : w_div_sel) : w_mul_res;
`else
  assign w_hi_nxt  = w_prod[2*XLEN-1:XLEN];
  assign w_lo_nxt  = w_prod[XLEN-1:0];
  assign w_final   = w_mul_res;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = w_special ? S_DONE : S_CALC;
      S_CALC: begin
        if (i_flush)                   w_state_nxt = S_IDLE;
        else if (r_cnt == CW'(1))      w_state_nxt = S_DONE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: iteration registers carry no reset; they are always loaded on accept before use.
  always_ff @(posedge i_clk) begin
    if (r_state == S_IDLE && w_accept) begin
      r_hi     <= '0;
      r_lo     <= w_mag_a;
      r_mag_b  <= w_mag_b;
      r_neg    <= w_neg_res;
      r_mul_lo <= (i_func3 == 3'b000);
      r_cnt    <= CW'(XLEN);
`ifdef ALU_CTRL_MD_DIV_EN
      r_div    <= i_func3[2];
      r_rem    <= i_func3[1];
`endif
    end else if (r_state == S_CALC) begin
      r_hi  <= w_hi_nxt;
      r_lo  <= w_lo_nxt;
      r_cnt <= r_cnt - CW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_result <= '0;
    end else if (r_state == S_IDLE && w_accept && w_special) begin
      r_result <= w_special_res;
    end else if (r_state == S_CALC && !i_flush && r_cnt == CW'(1)) begin
      r_result <= w_final;
    end
  end

  assign o_stall     = ~i_rst & (((r_state == S_IDLE) & w_accept) | (r_state == S_CALC));
  assign o_md_valid  = (r_state == S_DONE) & ~i_flush;
  assign o_md_result = r_result;

endmodule

// File: tb/tb_alu_ctrl_md.sv
module tb_alu_ctrl_md;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [2:0]  alu_op = 3'b000;
  logic [2:0]  func3 = 3'b000;
  logic [6:0]  func7 = 7'b0000000;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        flush = 1'b0;
  logic [3:0]  alu_ctrl;
  logic        md_sel, illegal, stall, md_valid;
  logic [31:0] md_result;

  int n_checks = 0;
  int n_errors = 0;

  alu_ctrl_md #(.XLEN(32)) dut (
    .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .i_alu_op(alu_op),
    .i_func3(func3), .i_func7(func7), .i_op_a(op_a), .i_op_b(op_b),
    .i_flush(flush), .o_alu_ctrl(alu_ctrl), .o_md_sel(md_sel),
    .o_illegal(illegal), .o_stall(stall), .o_md_valid(md_valid),
    .o_md_result(md_result)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    // M-op presented during reset must not stall.
    in_valid = 1'b1; alu_op = 3'b000; func7 = 7'h01; func3 = 3'b000;
    op_a = 32'd3; op_b = 32'd4;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL reset_stall got %b want 0", stall); end
    n_checks++; if (md_valid !== 1'b0) begin n_errors++; $display("FAIL reset_md_valid got %b want 0", md_valid); end
    n_checks++; if (md_result !== 32'h0) begin n_errors++; $display("FAIL reset_md_result got %h want 0", md_result); end
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic dec_vec(input string name, input logic [2:0] op, input logic [2:0] f3,
                         input logic [6:0] f7, input logic chk_ctrl, input logic [3:0] exp_ctrl,
                         input logic exp_ill, input logic exp_md);
    alu_op = op; func3 = f3; func7 = f7;
    #1;
    if (chk_ctrl) begin
      n_checks++;
      if (alu_ctrl !== exp_ctrl) begin
        n_errors++; $display("FAIL dec_%s alu_ctrl got %b want %b", name, alu_ctrl, exp_ctrl);
      end
    end
    n_checks++;
    if (illegal !== exp_ill) begin
      n_errors++; $display("FAIL dec_%s illegal got %b want %b", name, illegal, exp_ill);
    end
    n_checks++;
    if (md_sel !== exp_md) begin
      n_errors++; $display("FAIL dec_%s md_sel got %b want %b", name, md_sel, exp_md);
    end
  endtask

  task automatic test_decode();
    dec_vec("r_add",   3'b000, 3'b000, 7'h00, 1, 4'b0010, 0, 0);
    dec_vec("r_sub",   3'b000, 3'b000, 7'h20, 1, 4'b0110, 0, 0);
    dec_vec("r_sll",   3'b000, 3'b001, 7'h00, 1, 4'b1110, 0, 0);
    dec_vec("r_slt",   3'b000, 3'b010, 7'h00, 1, 4'b0111, 0, 0);
    dec_vec("r_sltu",  3'b000, 3'b011, 7'h00, 1, 4'b1001, 0, 0);
    dec_vec("r_xor",   3'b000, 3'b100, 7'h00, 1, 4'b1100, 0, 0);
    dec_vec("r_srl",   3'b000, 3'b101, 7'h00, 1, 4'b1101, 0, 0);
    dec_vec("r_sra",   3'b000, 3'b101, 7'h20, 1, 4'b1111, 0, 0);
    dec_vec("r_or",    3'b000, 3'b110, 7'h00, 1, 4'b0001, 0, 0);
    dec_vec("r_and",   3'b000, 3'b111, 7'h00, 1, 4'b0000, 0, 0);
    dec_vec("r_alt_bad_f3", 3'b000, 3'b111, 7'h20, 0, 4'b0000, 1, 0);
    dec_vec("r_alt_bad_sll", 3'b000, 3'b001, 7'h20, 0, 4'b0000, 1, 0);
    dec_vec("r_bad_f7", 3'b000, 3'b000, 7'h02, 0, 4'b0000, 1, 0);
    dec_vec("i_add_alt", 3'b110, 3'b000, 7'h20, 1, 4'b0010, 0, 0);
    dec_vec("i_add",   3'b110, 3'b000, 7'h00, 1, 4'b0010, 0, 0);
    dec_vec("i_srai",  3'b110, 3'b101, 7'h20, 1, 4'b1111, 0, 0);
    dec_vec("i_srli",  3'b110, 3'b101, 7'h00, 1, 4'b1101, 0, 0);
    dec_vec("i_slti",  3'b110, 3'b010, 7'h00, 1, 4'b0111, 0, 0);
    dec_vec("i_sltiu", 3'b110, 3'b011, 7'h00, 1, 4'b1001, 0, 0);
    dec_vec("i_ori",   3'b110, 3'b110, 7'h00, 1, 4'b0001, 0, 0);
    dec_vec("i_m_f7",  3'b110, 3'b000, 7'h01, 1, 4'b0010, 0, 0);
    dec_vec("i_odd_f7", 3'b110, 3'b001, 7'h02, 1, 4'b1110, 0, 0);
    dec_vec("load",    3'b001, 3'b010, 7'h20, 1, 4'b0010, 0, 0);
    dec_vec("store",   3'b010, 3'b010, 7'h00, 1, 4'b0010, 0, 0);
    dec_vec("u",       3'b100, 3'b111, 7'h20, 1, 4'b0010, 0, 0);
    dec_vec("jalr",    3'b111, 3'b000, 7'h00, 1, 4'b0010, 0, 0);
    dec_vec("j",       3'b101, 3'b011, 7'h00, 1, 4'b0000, 0, 0);
    dec_vec("beq",     3'b011, 3'b000, 7'h00, 1, 4'b0110, 0, 0);
    dec_vec("bne",     3'b011, 3'b001, 7'h00, 1, 4'b0110, 0, 0);
    dec_vec("blt",     3'b011, 3'b100, 7'h00, 1, 4'b0111, 0, 0);
    dec_vec("bge",     3'b011, 3'b101, 7'h00, 1, 4'b0111, 0, 0);
    dec_vec("bltu",    3'b011, 3'b110, 7'h00, 1, 4'b1001, 0, 0);
    dec_vec("bgeu",    3'b011, 3'b111, 7'h00, 1, 4'b1001, 0, 0);
    dec_vec("m_mul",   3'b000, 3'b000, 7'h01, 1, 4'b0010, 0, 1);
    dec_vec("m_mulhu", 3'b000, 3'b011, 7'h01, 1, 4'b0010, 0, 1);
`ifdef ALU_CTRL_MD_DIV_EN
    dec_vec("m_rem",   3'b000, 3'b110, 7'h01, 1, 4'b0010, 0, 1);
`else
    dec_vec("m_rem",   3'b000, 3'b110, 7'h01, 1, 4'b0010, 1, 0);
`endif
  endtask

  // Presents an M-op in the current cycle (caller is just past a rising edge)
  // and holds it until md_valid; checks latency, result and stall length.
  task automatic run_md(input string name, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    int stall_cnt = 0;
    int lat = -1;
    logic [31:0] res = 'x;
    in_valid = 1'b1; alu_op = 3'b000; func7 = 7'h01; func3 = f3; op_a = a; op_b = b;
    for (int cyc = 0; cyc < 100 && lat < 0; cyc++) begin
      @(negedge clk);
      if (stall) stall_cnt++;
      if (md_valid) begin lat = cyc; res = md_result; end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    n_checks++;
    if (lat != exp_lat) begin
      n_errors++; $display("FAIL %s latency got %0d want %0d", name, lat, exp_lat);
    end
    n_checks++;
    if (res !== exp_res) begin
      n_errors++; $display("FAIL %s result got %h want %h", name, res, exp_res);
    end
    n_checks++;
    if (stall_cnt != exp_lat) begin
      n_errors++; $display("FAIL %s stall_cycles got %0d want %0d", name, stall_cnt, exp_lat);
    end
  endtask

  task automatic test_multiply();
    @(posedge clk); #1;
    run_md("mulh_neg",  3'b001, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 33);
    run_md("mul_small", 3'b000, 32'd7,        32'd6,        32'h0000002A, 33);
    run_md("mul_low",   3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 33);
    run_md("mulhu",     3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
    run_md("mulhsu",    3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33);
  endtask

  task automatic test_back_to_back();
    @(posedge clk); #1;
    run_md("b2b_first",  3'b000, 32'd1000, 32'd1000, 32'd1000000, 33);
    run_md("b2b_second", 3'b011, 32'h80000000, 32'h00000004, 32'h00000002, 33);
  endtask

  task automatic test_flush();
    int bad_valid = 0;
    // Flush in IDLE blocks accept.
    @(posedge clk); #1;
    in_valid = 1'b1; alu_op = 3'b000; func7 = 7'h01; func3 = 3'b000;
    op_a = 32'd3; op_b = 32'd5; flush = 1'b1;
    #1;
    n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL flush_idle_stall got %b want 0", stall); end
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    #1;
    n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL flush_idle_no_accept stall got %b want 0", stall); end
    // Flush at T+10 of a MUL.
    @(posedge clk); #1;
    in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (md_valid) bad_valid++;
      @(posedge clk); #1;
    end
    flush = 1'b1;
    @(negedge clk);
    if (md_valid) bad_valid++;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    #1;
    n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL flush_stall_t11 got %b want 0", stall); end
    n_checks++; if (bad_valid != 0) begin n_errors++; $display("FAIL flush_md_valid got %0d pulses want 0", bad_valid); end
    run_md("mul_after_flush", 3'b000, 32'h12345678, 32'h00000010, 32'h23456780, 33);
  endtask

  task automatic test_reset_mid();
    int bad_valid = 0;
    @(posedge clk); #1;
    in_valid = 1'b1; alu_op = 3'b000; func7 = 7'h01; func3 = 3'b000;
    op_a = 32'd2; op_b = 32'd3;
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL rst_mid_stall got %b want 0", stall); end
    n_checks++; if (md_valid !== 1'b0) begin n_errors++; $display("FAIL rst_mid_md_valid got %b want 0", md_valid); end
    n_checks++; if (md_result !== 32'h0) begin n_errors++; $display("FAIL rst_mid_md_result got %h want 0", md_result); end
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL rst_mid_idle stall got %b want 0", stall); end
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (md_valid) bad_valid++;
    end
    n_checks++; if (bad_valid != 0) begin n_errors++; $display("FAIL rst_mid_late_valid got %0d want 0", bad_valid); end
  endtask

`ifdef ALU_CTRL_MD_DIV_EN
  task automatic test_divide();
    @(posedge clk); #1;
    run_md("div_neg",  3'b100, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 33);
    run_md("rem_neg",  3'b110, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 33);
    run_md("divu",     3'b101, 32'd100,      32'd7,        32'd14,       33);
    run_md("remu",     3'b111, 32'd100,      32'd7,        32'd2,        33);
    run_md("divu_zero", 3'b101, 32'd100,     32'd0,        32'hFFFFFFFF, 1);
    run_md("remu_zero", 3'b111, 32'd100,     32'd0,        32'd100,      1);
    run_md("div_ovf",  3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run_md("rem_ovf",  3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);
  endtask
`else
  task automatic test_div_disabled();
    int stall_cnt = 0;
    int valid_cnt = 0;
    @(posedge clk); #1;
    in_valid = 1'b1; alu_op = 3'b000; func7 = 7'h01; func3 = 3'b111;
    op_a = 32'd100; op_b = 32'd7;
    #1;
    n_checks++; if (illegal !== 1'b1) begin n_errors++; $display("FAIL nodiv_illegal got %b want 1", illegal); end
    n_checks++; if (md_sel !== 1'b0) begin n_errors++; $display("FAIL nodiv_md_sel got %b want 0", md_sel); end
    n_checks++; if (alu_ctrl !== 4'b0010) begin n_errors++; $display("FAIL nodiv_alu_ctrl got %b want 0010", alu_ctrl); end
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (stall) stall_cnt++;
      if (md_valid) valid_cnt++;
    end
    in_valid = 1'b0;
    n_checks++; if (stall_cnt != 0) begin n_errors++; $display("FAIL nodiv_stall got %0d cycles want 0", stall_cnt); end
    n_checks++; if (valid_cnt != 0) begin n_errors++; $display("FAIL nodiv_md_valid got %0d want 0", valid_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_decode();
    test_multiply();
    test_back_to_back();
    test_flush();
    test_reset_mid();
`ifdef ALU_CTRL_MD_DIV_EN
    test_divide();
`else
    test_div_disabled();
`endif
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
